// File: rtl/serial_twos_comp_mc_if.sv
// Bit-serial lane bundle for serial_twos_comp_mc: per-beat framing and input bits in,
// registered result bits, word marker and overflow flags out.
interface serial_twos_comp_mc_if #(
    parameter int LANES = 2
);
    logic             start;
    logic             bit_vld;
    logic [LANES-1:0] din;
    logic [LANES-1:0] neg;
    logic [LANES-1:0] dout;
    logic             dout_vld;
    logic             last;
    logic [LANES-1:0] ovf;

    modport master (
        output start, bit_vld, din, neg,
        input  dout, dout_vld, last, ovf
    );

    modport slave (
        input  start, bit_vld, din, neg,
        output dout, dout_vld, last, ovf
    );
endinterface

// File: rtl/serial_twos_comp_mc.sv
// Multi-lane word-framed bit-serial two's-complement negate/pass unit, LSB first, 1-cycle latency.
// Optional overflow detection (input == -2^(WIDTH-1) on a negate lane) is built when SERIAL_TC_OVF_EN is defined.
module serial_twos_comp_mc #(
    parameter int WIDTH = 8,
    parameter int LANES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_twos_comp_mc_if.slave  bus
);
    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MSB = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LANES-1:0] mode_q, mode_d;
    logic [LANES-1:0] seen_q, seen_d;
    logic [LANES-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             last_q, last_d;

    logic             accept;
    logic             msb_beat;
    logic [LANES-1:0] s_eff;
    logic [LANES-1:0] m_eff;
    logic [LANES-1:0] result;

    // A start beat behaves as bit 0 of a fresh word: seen history is ignored and neg is used directly.
    always_comb begin
        s_eff    = bus.start ? '0 : seen_q;
        m_eff    = bus.start ? bus.neg : mode_q;
        result   = bus.din ^ (m_eff & s_eff);
        accept   = bus.bit_vld & (bus.start | (state_q == RUN));
        msb_beat = accept & ~bus.start & (cnt_q == CNT_MSB);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        seen_d     = seen_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        last_d     = 1'b0;
        if (accept) begin
            dout_d     = result;
            dout_vld_d = 1'b1;
            last_d     = msb_beat;
            mode_d     = m_eff;
            seen_d     = s_eff | (m_eff & bus.din);
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    cnt_d   = CW'(1);
                end
                RUN: begin
                    if (bus.start) begin
                        cnt_d = CW'(1);
                    end else if (msb_beat) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mode_q     <= '0;
            seen_q     <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            seen_q     <= seen_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            last_q     <= last_d;
        end
    end

`ifdef SERIAL_TC_OVF_EN
    logic [LANES-1:0] ovf_q, ovf_d;

    // No 1 below the MSB plus a set MSB means the word is exactly -2^(WIDTH-1).
    always_comb begin
        ovf_d = '0;
        if (msb_beat) begin
            ovf_d = m_eff & ~s_eff & bus.din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = '0;
`endif

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.last     = last_q;
endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// Bench for serial_twos_comp_mc: table vectors, corner sequences and random words against an arithmetic model.
module tb_serial_twos_comp_mc;
    localparam int W = 8;
    localparam int L = 2;
`ifdef SERIAL_TC_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    serial_twos_comp_mc_if #(.LANES(L)) bus ();

    serial_twos_comp_mc #(.WIDTH(W), .LANES(L)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic [L-1:0] n;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic [L-1:0] eovf;
    } vec_t;

    typedef struct packed {
        logic [L-1:0][W-1:0] w;
        logic [L-1:0]        ovf;
    } res_t;

    int checks = 0;
    int errors = 0;

    // Framing model: whether a word is in flight and how many bits of it were accepted.
    bit mrun  = 1'b0;
    int mbits = 0;

    int                  pos = 0;
    logic [L-1:0][W-1:0] acc_w;
    logic [L-1:0]        prev_dout = '0;
    res_t                got_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_tc(input logic [W-1:0] w, input logic n);
        return n ? W'(-int'(w)) : w;
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] w, input logic n);
        return OVF_EN && n && (int'(w) == (1 << (W - 1)));
    endfunction

    task automatic beat(input bit st, input bit v, input logic [L-1:0] d, input logic [L-1:0] n);
        bit acc_exp;
        bit last_exp;
        bus.start   = st;
        bus.bit_vld = v;
        bus.din     = d;
        bus.neg     = n;
        acc_exp  = v && (st || mrun);
        last_exp = acc_exp && !st && (mbits == W - 1);
        @(posedge clk);
        #1;
        if (acc_exp) begin
            if (st) begin
                mrun  = 1'b1;
                mbits = 1;
            end else begin
                mbits++;
            end
            if (last_exp) begin
                mrun  = 1'b0;
                mbits = 0;
            end
        end
        chk("dout_vld", {31'd0, bus.dout_vld}, {31'd0, acc_exp});
        chk("last", {31'd0, bus.last}, {31'd0, last_exp});
        if (!last_exp) chk("ovf_idle", 32'(bus.ovf), 32'd0);
        if (!acc_exp) chk("dout_hold", 32'(bus.dout), 32'(prev_dout));
        prev_dout = bus.dout;
        if (acc_exp && st) pos = 0;
        if (bus.dout_vld === 1'b1 && pos < W) begin
            for (int l = 0; l < L; l++) acc_w[l][pos] = bus.dout[l];
            pos++;
        end
        if (bus.last === 1'b1) begin
            res_t r;
            r.w   = acc_w;
            r.ovf = bus.ovf;
            got_q.push_back(r);
        end
    endtask

    task automatic send_bits(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [L-1:0] n,
                             input logic [W-1:0] stall, input int nb);
        for (int i = 0; i < nb; i++) begin
            beat(i == 0, 1'b1, {w1[i], w0[i]}, n);
            if (stall[i]) beat(1'b0, 1'b0, L'($urandom), L'($urandom));
        end
    endtask

    task automatic expect_word(input string nm, input logic [W-1:0] e0, input logic [W-1:0] e1,
                               input logic [L-1:0] eovf);
        res_t r;
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no completed word expected %0h/%0h", nm, e0, e1);
        end else begin
            r = got_q.pop_front();
            chk({nm, "_lane0"}, 32'(r.w[0]), 32'(e0));
            chk({nm, "_lane1"}, 32'(r.w[1]), 32'(e1));
            chk({nm, "_ovf"}, 32'(r.ovf), 32'(eovf));
        end
    endtask

    vec_t vecs[6];

    initial begin
        logic [L-1:0]   ovf_mask;
        logic [W-1:0]   rw0, rw1, rst_mask;
        logic [L-1:0]   rn;
        ovf_mask = OVF_EN ? {L{1'b1}} : {L{1'b0}};

        vecs[0] = '{8'h54, 8'h54, 2'b01, 8'hAC, 8'h54, 2'b00};
        vecs[1] = '{8'h00, 8'h00, 2'b01, 8'h00, 8'h00, 2'b00};
        vecs[2] = '{8'h01, 8'h7F, 2'b11, 8'hFF, 8'h81, 2'b00};
        vecs[3] = '{8'h80, 8'h80, 2'b01, 8'h80, 8'h80, 2'b01};
        vecs[4] = '{8'h80, 8'h80, 2'b11, 8'h80, 8'h80, 2'b11};
        vecs[5] = '{8'hFF, 8'h02, 2'b10, 8'hFF, 8'hFE, 2'b00};

        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.bit_vld = 1'b1;
        bus.din     = '1;
        bus.neg     = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_dout_vld", {31'd0, bus.dout_vld}, 32'd0);
        chk("rst_last", {31'd0, bus.last}, 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        bus.start   = 1'b0;
        bus.bit_vld = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send_bits(vecs[i].w0, vecs[i].w1, vecs[i].n, '0, W);
            expect_word($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].eovf & ovf_mask);
        end

        // Stalls after bits 2 and 5.
        send_bits(8'h54, 8'h01, 2'b11, 8'b0010_0100, W);
        expect_word("stall", 8'hAC, 8'hFF, 2'b00);

        // Back-to-back words, no idle cycle between them.
        send_bits(8'h54, 8'h54, 2'b01, '0, W);
        send_bits(8'h01, 8'h01, 2'b01, '0, W);
        expect_word("b2b_first", 8'hAC, 8'h54, 2'b00);
        expect_word("b2b_second", 8'hFF, 8'h01, 2'b00);

        // Abort: four bits of 0x54, then restart at bit 4 with 0x03.
        send_bits(8'h54, 8'h54, 2'b01, '0, 4);
        send_bits(8'h03, 8'h03, 2'b01, '0, W);
        expect_word("abort", 8'hFD, 8'h03, 2'b00);
        chk("abort_extra_words", got_q.size(), 32'd0);

        // Reset asserted in the middle of bit 3.
        send_bits(8'h54, 8'h54, 2'b11, '0, 3);
        bus.start   = 1'b0;
        bus.bit_vld = 1'b1;
        bus.din     = 2'b00;
        #2 reset = 1'b1;
        #1;
        chk("midrst_dout", 32'(bus.dout), 32'd0);
        chk("midrst_dout_vld", {31'd0, bus.dout_vld}, 32'd0);
        chk("midrst_last", {31'd0, bus.last}, 32'd0);
        chk("midrst_ovf", 32'(bus.ovf), 32'd0);
        mrun      = 1'b0;
        mbits     = 0;
        prev_dout = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) beat(1'b0, 1'b1, L'($urandom), L'($urandom));
        send_bits(8'h54, 8'h54, 2'b01, '0, W);
        expect_word("after_rst", 8'hAC, 8'h54, 2'b00);
        chk("after_rst_extra_words", got_q.size(), 32'd0);

        for (int k = 0; k < 24; k++) begin
            rw0      = (k % 6 == 0) ? 8'h80 : W'($urandom);
            rw1      = W'($urandom);
            rn       = L'($urandom);
            rst_mask = W'($urandom & $urandom & $urandom);
            send_bits(rw0, rw1, rn, rst_mask, W);
            expect_word($sformatf("rand%0d", k), ref_tc(rw0, rn[0]), ref_tc(rw1, rn[1]),
                        {ref_ovf(rw1, rn[1]), ref_ovf(rw0, rn[0])});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
